// File: rtl/llr_pack_pkg.sv
// Shared types for the LLR frame packer: FSM encoding, default beat layout
// and the frame-counter width used when LLR_PACKER_FRAME_CNT_EN is defined.
package llr_pack_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } pack_state_e;

  localparam int LLR_DATA_W  = 8;
  localparam int LLR_PACK    = 4;
  localparam int LLR_BEAT_W  = LLR_DATA_W * LLR_PACK;
  localparam int FRAME_CNT_W = 16;

  // Beat layout for the default configuration; parameterised instances
  // build the same {data, last} shape locally.
  typedef struct packed {
    logic [LLR_BEAT_W-1:0] data;
    logic                  last;
  } llr_beat_t;

  // Stored width of one beat: all lanes plus the end-of-frame tag.
  function automatic int beat_width(input int data_w, input int pack);
    return data_w * pack + 1;
  endfunction

endpackage

// File: rtl/pack_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO; DEPTH must be a power of 2
// so the pointers wrap naturally.
module pack_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             pop_eff, push_eff;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop on empty is ignored; a push on full only lands if a pop frees a slot.
  assign pop_eff  = pop_i & ~empty_o;
  assign push_eff = push_i & (~full_o | pop_eff);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_eff) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_eff)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push_eff, pop_eff})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/llr_frame_packer.sv
// Packs PACK consecutive LLR words into tagged beats and queues them through a
// FWFT FIFO. Optional o_frame_cnt port under macro LLR_PACKER_FRAME_CNT_EN.
module llr_frame_packer
  import llr_pack_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PACK        = 4,
  parameter int FRAME_BEATS = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_valid,
  input  logic                           i_sof,
  input  logic [DATA_WIDTH-1:0]          i_data,
  output logic                           o_valid,
  input  logic                           o_ready,
  output logic [PACK*DATA_WIDTH-1:0]     o_data,
  output logic                           o_last,
  output logic [$clog2(FIFO_DEPTH):0]    o_level,
  output logic                           o_ovf,
  output logic                           o_err_sof
`ifdef LLR_PACKER_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0]         o_frame_cnt
`endif
);

  localparam int WCW    = $clog2(PACK);
  localparam int BCW    = $clog2(FRAME_BEATS);
  localparam int BEAT_W = beat_width(DATA_WIDTH, PACK);

  typedef struct packed {
    logic [PACK*DATA_WIDTH-1:0] data;
    logic                       last;
  } beat_t;

  pack_state_e                       state_q, state_d;
  logic [WCW-1:0]                    word_cnt_q, word_cnt_d;
  logic [BCW-1:0]                    beat_cnt_q, beat_cnt_d;
  logic [PACK-1:0][DATA_WIDTH-1:0]   lanes_q, lanes_d;
  logic [PACK-1:0][DATA_WIDTH-1:0]   merged;
  logic                              err_sof_q, err_sof_d;
  logic                              ovf_q, ovf_d;
  logic                              push;
  logic                              last_beat;
  beat_t                             push_beat;
  beat_t                             head_beat;
  logic [BEAT_W-1:0]                 head_raw;
  logic                              fifo_full, fifo_empty;

  // The incoming word is merged into the lane image so a completing beat can
  // be pushed on the same edge as its final word.
  always_comb begin
    merged                 = lanes_q;
    merged[word_cnt_q]     = i_data;
    last_beat              = (beat_cnt_q == BCW'(FRAME_BEATS - 1));
    push_beat.data         = merged;
    push_beat.last         = last_beat;
  end

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    beat_cnt_d = beat_cnt_q;
    lanes_d    = lanes_q;
    err_sof_d  = err_sof_q;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_valid && i_sof) begin
          lanes_d[0] = i_data;
          word_cnt_d = WCW'(1);
          beat_cnt_d = '0;
          state_d    = COLLECT;
        end
      end
      COLLECT: begin
        if (i_valid && i_sof) begin
          // Abort the partial beat and restart the frame on this word.
          err_sof_d  = 1'b1;
          lanes_d[0] = i_data;
          word_cnt_d = WCW'(1);
          beat_cnt_d = '0;
        end else if (i_valid) begin
          if (word_cnt_q == WCW'(PACK - 1)) begin
            push       = 1'b1;
            word_cnt_d = '0;
            if (last_beat) begin
              beat_cnt_d = '0;
              state_d    = IDLE;
            end else begin
              beat_cnt_d = beat_cnt_q + BCW'(1);
            end
          end else begin
            lanes_d    = merged;
            word_cnt_d = word_cnt_q + WCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Framing counters advance even if the FIFO drops the beat.
  assign ovf_d = ovf_q | (push & fifo_full & ~o_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      beat_cnt_q <= '0;
      lanes_q    <= '0;
      err_sof_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      lanes_q    <= lanes_d;
      err_sof_q  <= err_sof_d;
      ovf_q      <= ovf_d;
    end
  end

  pack_sync_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (push_beat),
    .pop_i   (o_ready),
    .rdata_o (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (o_level)
  );

  // Head is masked while empty so stale storage never reaches the outputs.
  assign head_beat = head_raw;
  assign o_valid   = ~fifo_empty;
  assign o_data    = o_valid ? head_beat.data : '0;
  assign o_last    = o_valid & head_beat.last;
  assign o_ovf     = ovf_q;
  assign o_err_sof = err_sof_q;

`ifdef LLR_PACKER_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (o_valid && o_ready && o_last) begin
      frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
    end
  end

  assign o_frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_llr_frame_packer.sv
// Randomised scoreboard bench for llr_frame_packer with a frame-level reference
// model; o_frame_cnt is checked when LLR_PACKER_FRAME_CNT_EN is defined.
module tb_llr_frame_packer;

  localparam int DW = 8;
  localparam int PK = 4;
  localparam int FB = 2;
  localparam int FD = 4;
  localparam int BW = DW * PK;
  localparam int LW = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_sof = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_ready = 1'b0;
  logic          o_valid;
  logic [BW-1:0] o_data;
  logic          o_last;
  logic [LW-1:0] o_level;
  logic          o_ovf;
  logic          o_err_sof;
`ifdef LLR_PACKER_FRAME_CNT_EN
  logic [15:0]   o_frame_cnt;
`endif

  llr_frame_packer #(
    .DATA_WIDTH  (DW),
    .PACK        (PK),
    .FRAME_BEATS (FB),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .i_sof     (i_sof),
    .i_data    (i_data),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .o_last    (o_last),
    .o_level   (o_level),
    .o_ovf     (o_ovf),
    .o_err_sof (o_err_sof)
`ifdef LLR_PACKER_FRAME_CNT_EN
    ,
    .o_frame_cnt (o_frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
  } exp_beat_t;

  // Scoreboard of beats the model says the FIFO accepted, in order.
  exp_beat_t exp_q[$];

  // Reference model state: words of the frame in progress, beat index,
  // modelled FIFO occupancy and sticky flags.
  int  cur_words[$];
  bit  in_frame  = 0;
  int  beat_idx  = 0;
  int  m_count   = 0;
  bit  m_ovf     = 0;
  bit  m_err     = 0;
  int  m_frames  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluates each clock edge from the inputs held across it.
  always @(posedge clk) begin : model
    bit        pop;
    bit        have;
    exp_beat_t nb;
    if (!rst_n) begin
      m_count  = 0;
      m_ovf    = 0;
      m_err    = 0;
      m_frames = 0;
      in_frame = 0;
      beat_idx = 0;
      cur_words.delete();
      exp_q.delete();
    end else begin
      pop  = (m_count > 0) && o_ready;
      have = 0;
      nb   = '0;
      if (i_valid) begin
        if (i_sof) begin
          if (in_frame) m_err = 1;
          cur_words.delete();
          cur_words.push_back(int'(i_data));
          in_frame = 1;
          beat_idx = 0;
        end else if (in_frame) begin
          cur_words.push_back(int'(i_data));
          if (cur_words.size() == PK) begin
            for (int k = 0; k < PK; k++)
              nb.data = nb.data | (BW'(cur_words[k]) << (k * DW));
            nb.last = (beat_idx == FB - 1);
            have    = 1;
            beat_idx++;
            cur_words.delete();
            if (nb.last) begin
              in_frame = 0;
              beat_idx = 0;
            end
          end
        end
      end
      if (have) begin
        if (m_count < FD || pop) begin
          exp_q.push_back(nb);
          m_count++;
        end else begin
          m_ovf = 1;
        end
      end
      if (pop) m_count--;
    end
  end

  // Monitor: samples on the falling edge, pops the scoreboard on handshakes.
  always @(negedge clk) begin : monitor
    exp_beat_t eb;
    chk("level", 64'(o_level), 64'(m_count));
    chk("valid", 64'(o_valid), 64'(m_count > 0));
    chk("ovf", 64'(o_ovf), 64'(m_ovf));
    chk("err_sof", 64'(o_err_sof), 64'(m_err));
`ifdef LLR_PACKER_FRAME_CNT_EN
    chk("frame_cnt", 64'(o_frame_cnt), 64'(m_frames[15:0]));
`endif
    if (!o_valid) begin
      chk("idle_data", 64'(o_data), 64'd0);
      chk("idle_last", 64'(o_last), 64'd0);
    end else if (o_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 64'(o_data), 64'hDEAD_0000_0000);
      end else begin
        eb = exp_q.pop_front();
        chk("beat_data", 64'(o_data), 64'(eb.data));
        chk("beat_last", 64'(o_last), 64'(eb.last));
        if (eb.last) m_frames++;
      end
    end
  end

  task automatic drv(input bit v, input bit s, input logic [DW-1:0] d, input bit r);
    i_valid = v;
    i_sof   = s;
    i_data  = d;
    o_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit r);
    for (int k = 0; k < n; k++) drv(0, 0, '0, r);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv(0, 0, '0, 0);
    rst_n = 1'b1;
  endtask

  // One whole frame of PK*FB words starting at 'base', optionally gapped.
  task automatic frame(input int base, input bit gap, input bit r);
    for (int k = 0; k < PK * FB; k++) begin
      if (gap && k > 0) drv(0, 0, '0, r);
      drv(1, (k == 0), DW'(base + k), r);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_level", 64'(o_level), 64'd0);
    chk("reset_valid", 64'(o_valid), 64'd0);
    rst_n = 1'b1;

    // Nominal back-to-back frame 0x01..0x08
    frame(1, 0, 1);
    idle(3, 1);

    // Same words with gaps between them
    frame(1, 1, 1);
    idle(3, 1);
    chk("gap_err_sof", 64'(o_err_sof), 64'd0);

    // Backpressure: three frames into a 4-deep FIFO
    do_reset();
    frame(8'h10, 0, 0);
    frame(8'h20, 0, 0);
    frame(8'h30, 0, 0);
    idle(2, 0);
    chk("bp_level", 64'(o_level), 64'd4);
    chk("bp_ovf", 64'(o_ovf), 64'd1);
    idle(8, 1);

    // Mid-frame sof aborts 0xAA/0xBB
    drv(1, 1, 8'hAA, 1);
    drv(1, 0, 8'hBB, 1);
    for (int k = 0; k < 8; k++) drv(1, (k == 0), DW'(8'h11 * (k + 1)), 1);
    idle(3, 1);
    chk("mid_err_sof", 64'(o_err_sof), 64'd1);

    // Full FIFO with a pop on the cycle a beat completes
    do_reset();
    frame(8'h40, 0, 0);
    frame(8'h50, 0, 0);
    drv(1, 1, 8'h60, 0);
    drv(1, 0, 8'h61, 0);
    drv(1, 0, 8'h62, 0);
    drv(1, 0, 8'h63, 1);
    idle(1, 0);
    chk("full_pp_level", 64'(o_level), 64'd4);
    chk("full_pp_ovf", 64'(o_ovf), 64'd0);
    idle(6, 1);

    // Reset mid-frame, then words without sof are dropped
    drv(1, 1, 8'h70, 0);
    drv(1, 0, 8'h71, 0);
    rst_n = 1'b0;
    drv(1, 0, 8'h72, 1);
    rst_n = 1'b1;
    chk("rst_mid_level", 64'(o_level), 64'd0);
    chk("rst_mid_ovf", 64'(o_ovf), 64'd0);
    for (int k = 0; k < 6; k++) drv(1, 0, DW'(8'h80 + k), 1);
    chk("rst_drop_level", 64'(o_level), 64'd0);

    // Randomised traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      bit v;
      bit s;
      v = ($urandom_range(0, 3) != 0);
      s = v && ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
      drv(v, s, DW'($urandom), ($urandom_range(0, 2) != 0));
      rst_n = 1'b1;
    end

    idle(20, 1);
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/llr_frame_packer.md
Name: llr_frame_packer

Overview:
- Consumer stage directly downstream of the decoder's fixed-latency delay line.
- Takes the delayed per-cycle LLR word stream (valid + start-of-frame, no backpressure) and packs PACK consecutive words into one wide beat.
- Tags the final beat of each frame and hands beats to the decoder core over a valid/ready handshake through an internal FIFO.
- Flags overflow and framing errors.

Parameters:
- DATA_WIDTH, 8, bits per LLR word
- PACK, 4, words per output beat (>=2)
- FRAME_BEATS, 16, beats per frame (>=2)
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_valid  in  1  input word valid (no ready; stream cannot stall)
- i_sof  in  1  first word of a frame, qualified by i_valid
- i_data  in  DATA_WIDTH  LLR word
- o_valid  out  1  output beat valid
- o_ready  in  1  downstream accepts beat
- o_data  out  PACK*DATA_WIDTH  packed beat, first word in LSBs (lane 0)
- o_last  out  1  beat is last of frame
- o_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- o_ovf  out  1  sticky: beat dropped on full FIFO
- o_err_sof  out  1  sticky: i_sof seen mid-frame

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM IDLE, word/beat counters 0, lane register 0.
- FSM IDLE: i_valid&~i_sof words dropped silently. i_valid&i_sof writes lane 0, sets word_cnt=1 and beat_cnt=0, and goes to COLLECT.
- FSM COLLECT: each i_valid writes lane word_cnt and increments word_cnt.
  - When the PACKth word is written, the beat completes: push {lanes, last=(beat_cnt==FRAME_BEATS-1)} into the FIFO the same cycle, clear word_cnt, increment beat_cnt.
  - After the last beat, return to IDLE.
- The completing word is merged combinationally into the push data. There is no extra bubble.
- i_sof in COLLECT: set o_err_sof and discard the partial beat. Already-pushed beats of the aborted frame stay in the FIFO, with no o_last.
  - Restart as a new frame with this word in lane 0, word_cnt=1, beat_cnt=0.
- Gaps (i_valid=0) in COLLECT: hold state indefinitely; no timeout.
- FIFO behaviour:
  - First-word-fall-through. o_valid=1 whenever level>0; o_data/o_last show the head entry.
  - Pop on o_valid&o_ready.
  - Latency: the beat completing at edge t is visible on o_valid after edge t (one register stage).
- Push when full and no pop the same cycle: beat dropped, o_ovf set. Frame counters advance as if it were accepted, so framing stays aligned.
- Push and pop the same cycle when full: both accepted, level unchanged, no ovf.
- Push and pop the same cycle when empty: push accepted; the pop is illegal because o_valid=0, so level becomes 1.
- Pointers wrap modulo FIFO_DEPTH. o_level ranges 0..FIFO_DEPTH.
- Sticky flags clear only on reset.
- Reset mid-frame or with a non-empty FIFO: everything returns to reset values on the next edge. Partial beats and stored beats are lost.

Optional Feature:
- Macro: LLR_PACKER_FRAME_CNT_EN.
- Defined: adds port o_frame_cnt (out, 16). It increments, wrapping at 16 bits, on every pop with o_last=1. Reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package llr_pack_pkg:
  - FSM state enum {IDLE, COLLECT}.
  - Beat struct typedef {data, last}, parameterised via localparam widths.
  - Frame-counter width localparam (16).
- Sub-module pack_sync_fifo:
  - Generic FWFT synchronous FIFO (width, depth), with push/pop/full/empty/level.
  - Reusable elsewhere in the decoder.

Test Plan:
- Nominal frame: DATA_WIDTH=8, PACK=4, FRAME_BEATS=2, o_ready=1. Drive sof + words 0x01..0x08 back-to-back. Expect beat0=0x04030201 with last=0, then beat1=0x08070605 with last=1. Each beat appears 1 cycle after its 4th word.
- Gapped input: same 8 words with i_valid toggling 1/0. Expect identical beats and o_err_sof=0.
- Backpressure/overflow: FIFO_DEPTH=4, o_ready=0, drive 3 frames (6 beats). Expect o_level=4, o_ovf=1, and the first 4 beats retained. Release o_ready: exactly 4 pops, contents of beats 0..3.
- Mid-frame sof: sof, 0xAA, 0xBB, then sof+0x11, 0x22..0x88. Expect o_err_sof=1, 0xAA/0xBB never output, then beats 0x44332211 and 0x88776655 (last=1).
- Full simultaneous push/pop: FIFO full, o_ready=1 on the cycle a beat completes. Expect level stays 4 and o_ovf stays 0.
- Reset mid-frame: assert rst_n=0 after 2 words. Expect all outputs 0 next cycle and o_level=0; words without sof after release are dropped.
